// File: rtl/nor_target_emu.sv
// nor_target_emu: parallel-NOR target with JEDEC unlock/program commands, RY/BY# and data-polling status.
// Sector erase (80h/AA/55/30) is compiled in only when NOR_EMU_ERASE_EN is defined.
`ifndef NORADDRBITS
`define NORADDRBITS 20
`endif
`ifndef NORDATABITS
`define NORDATABITS 16
`endif

module nor_target_emu #(
  parameter int MEMWBADDRBITS = `NORADDRBITS,
  parameter int MEMWBDATABITS = `NORDATABITS,
  parameter int MEMBITS       = 10,
  parameter int SECTBITS      = 6,
  parameter int PROG_CYCLES   = 16
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_i,
  input  logic                     nor_ce_i,
  input  logic                     nor_we_i,
  input  logic                     nor_oe_i,
  input  logic [MEMWBADDRBITS-1:0] nor_addr_i,
  input  logic [MEMWBDATABITS-1:0] nor_data_i,
  output logic [MEMWBDATABITS-1:0] nor_data_o,
  output logic                     nor_data_oe,
  output logic                     nor_ry_o
);

  localparam int CMPBITS     = (MEMBITS > 11) ? MEMBITS : 11;
  localparam int PCBITS      = $clog2(PROG_CYCLES + 1);
  localparam int COUNTERBITS = ((PCBITS > SECTBITS) ? PCBITS : SECTBITS) + 1;
  localparam int MEM_WORDS   = 1 << MEMBITS;
  localparam logic [COUNTERBITS-1:0] PROG_LAST = COUNTERBITS'(PROG_CYCLES - 1);
`ifdef NOR_EMU_ERASE_EN
  localparam logic [COUNTERBITS-1:0] ERS_LAST  = COUNTERBITS'((1 << SECTBITS) - 1);
  localparam logic [MEMBITS-1:0]     SECT_MASK = ~MEMBITS'((1 << SECTBITS) - 1);
`endif

  typedef enum logic [3:0] {
    IDLE,
    UNLK1,
    UNLK2,
    PROG,
    BUSY_PROG
`ifdef NOR_EMU_ERASE_EN
    ,
    ERS1,
    ERS2,
    ERS3,
    BUSY_ERASE
`endif
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNTERBITS-1:0]   cnt_q, cnt_d;
  logic                     wr_ph, rd_ph, commit, rd_entry, busy;
  logic                     wr_ph_p1, rd_ph_p1;
  logic [CMPBITS-1:0]       addr_p1;
  logic [MEMWBDATABITS-1:0] data_p1;
  logic [MEMBITS-1:0]       prog_addr_p1;
  logic [MEMWBDATABITS-1:0] prog_data_p1;
  logic                     prog_ld, prog_fin, prog_fin_p1;
  logic                     tog_q;
  logic                     at_555, at_2aa;
  logic [MEMWBDATABITS-1:0] status;
  logic                     unused_addr;
`ifdef NOR_EMU_ERASE_EN
  logic                     ers_ld;
  logic [MEMBITS-1:0]       ers_base_p1;
`endif

  // Words are stored inverted so a configuration-cleared RAM reads back as all-ones.
  logic [MEMWBDATABITS-1:0] mem_n [0:MEM_WORDS-1];

  assign unused_addr = ^nor_addr_i[MEMWBADDRBITS-1:CMPBITS];

  assign wr_ph    = !nor_ce_i && !nor_we_i;
  assign rd_ph    = !nor_ce_i && !nor_oe_i && nor_we_i;
  assign commit   = wr_ph_p1 && !wr_ph;
  assign rd_entry = rd_ph && !rd_ph_p1;
  assign at_555   = (addr_p1[10:0] == 11'h555);
  assign at_2aa   = (addr_p1[10:0] == 11'h2AA);

`ifdef NOR_EMU_ERASE_EN
  assign busy = (state_q == BUSY_PROG) || (state_q == BUSY_ERASE);
`else
  assign busy = (state_q == BUSY_PROG);
`endif

  always_comb begin
    status    = '0;
    status[6] = rd_entry ? tog_q : ~tog_q;
    if (state_q == BUSY_PROG) status[7] = ~prog_data_p1[7];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prog_ld  = 1'b0;
    prog_fin = 1'b0;
`ifdef NOR_EMU_ERASE_EN
    ers_ld   = 1'b0;
`endif
    case (state_q)
      IDLE:  if (commit) state_d = (at_555 && data_p1[7:0] == 8'hAA) ? UNLK1 : IDLE;
      UNLK1: if (commit) state_d = (at_2aa && data_p1[7:0] == 8'h55) ? UNLK2 : IDLE;
      UNLK2: begin
        if (commit) begin
          state_d = IDLE;
          if (at_555 && data_p1[7:0] == 8'hA0) state_d = PROG;
`ifdef NOR_EMU_ERASE_EN
          if (at_555 && data_p1[7:0] == 8'h80) state_d = ERS1;
`endif
        end
      end
      PROG: begin
        if (commit) begin
          state_d = BUSY_PROG;
          cnt_d   = '0;
          prog_ld = 1'b1;
        end
      end
      BUSY_PROG: begin
        if (cnt_q == PROG_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          prog_fin = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef NOR_EMU_ERASE_EN
      ERS1: if (commit) state_d = (at_555 && data_p1[7:0] == 8'hAA) ? ERS2 : IDLE;
      ERS2: if (commit) state_d = (at_2aa && data_p1[7:0] == 8'h55) ? ERS3 : IDLE;
      ERS3: begin
        if (commit) begin
          if (data_p1[7:0] == 8'h30) begin
            state_d = BUSY_ERASE;
            cnt_d   = '0;
            ers_ld  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BUSY_ERASE: begin
        if (cnt_q == ERS_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: control state, strobe history, busy flag
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ph_p1    <= 1'b0;
      rd_ph_p1    <= 1'b0;
      prog_fin_p1 <= 1'b0;
      tog_q       <= 1'b0;
      nor_ry_o    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ph_p1    <= wr_ph;
      rd_ph_p1    <= rd_ph;
      prog_fin_p1 <= prog_fin;
      if (busy && rd_entry) tog_q <= ~tog_q;
      nor_ry_o    <= !busy;
    end
  end

  // Stage p1: latched bus write and pending program/erase operands
  always_ff @(posedge sys_clk_i) begin
    if (wr_ph) begin
      addr_p1 <= nor_addr_i[CMPBITS-1:0];
      data_p1 <= nor_data_i;
    end
    if (prog_ld) begin
      prog_addr_p1 <= addr_p1[MEMBITS-1:0];
      prog_data_p1 <= ~mem_n[addr_p1[MEMBITS-1:0]] & data_p1;
    end
`ifdef NOR_EMU_ERASE_EN
    if (ers_ld) ers_base_p1 <= addr_p1[MEMBITS-1:0] & SECT_MASK;
`endif
  end

  // Stage p2: array update, aligned with RY/BY# release for programs
  always_ff @(posedge sys_clk_i) begin
    if (prog_fin_p1) begin
      mem_n[prog_addr_p1] <= ~prog_data_p1;
    end
`ifdef NOR_EMU_ERASE_EN
    else if (state_q == BUSY_ERASE) begin
      mem_n[ers_base_p1 | MEMBITS'(cnt_q[SECTBITS-1:0])] <= '0;
    end
`endif
  end

  // Stage p1: registered read port
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      nor_data_o  <= '0;
      nor_data_oe <= 1'b0;
    end else begin
      nor_data_oe <= rd_ph;
      if (rd_ph) nor_data_o <= busy ? status : ~mem_n[nor_addr_i[MEMBITS-1:0]];
    end
  end

endmodule

// File: tb/tb_nor_target_emu.sv
// Directed bench for nor_target_emu: reset, reads, program/status polling, broken sequences, erase/abort.
`timescale 1ns/1ps
module tb_nor_target_emu;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce_n, we_n, oe_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          doe;
  logic          ry;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nor_target_emu #(
    .MEMWBADDRBITS(AW),
    .MEMWBDATABITS(DW)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst_n),
    .nor_ce_i   (ce_n),
    .nor_we_i   (we_n),
    .nor_oe_i   (oe_n),
    .nor_addr_i (addr),
    .nor_data_i (wdata),
    .nor_data_o (rdata),
    .nor_data_oe(doe),
    .nor_ry_o   (ry)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = a; wdata = d; ce_n = 1'b0; we_n = 1'b0;
    @(negedge clk);
    we_n = 1'b1; ce_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic o);
    @(negedge clk);
    addr = a; ce_n = 1'b0; oe_n = 1'b0;
    @(negedge clk);
    d = rdata; o = doe;
    ce_n = 1'b1; oe_n = 1'b1;
  endtask

  task automatic cmd_prog(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h555, 16'h00A0);
    bus_write(a, d);
  endtask

  // Counts negedges with RY/BY# low, stopping once it returns high or the bound runs out.
  task automatic measure_low(input int bound, output int lows);
    lows = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!ry) lows++;
      else if (lows > 0) break;
    end
  endtask

  task automatic prog_wait(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int l;
    cmd_prog(a, d);
    measure_low(100, l);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    logic          ro;
    int            lows;

    rst_n = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    expect_eq("rst_data", rdata, 32'h0);
    expect_eq("rst_oe",   doe,   32'h0);
    expect_eq("rst_ry",   ry,    32'h1);
    rst_n = 1'b1;

    // Fresh array reads all-ones, OE drops one clock after the read ends
    bus_read(20'h012, rd, ro);
    expect_eq("fresh_data", rd, 32'hFFFF);
    expect_eq("fresh_oe",   ro, 32'h1);
    @(negedge clk);
    expect_eq("fresh_oe_fall", doe, 32'h0);

    // Reset asserted mid-clock clears outputs without waiting for an edge
    @(negedge clk);
    addr = 20'h012; ce_n = 1'b0; oe_n = 1'b0;
    @(negedge clk);
    expect_eq("pre_rst_oe", doe, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    expect_eq("async_rst_data", rdata, 32'h0);
    expect_eq("async_rst_oe",   doe,   32'h0);
    expect_eq("async_rst_ry",   ry,    32'h1);
    @(negedge clk);
    ce_n = 1'b1; oe_n = 1'b1; rst_n = 1'b1;

    // Program 1234 at 0x012
    cmd_prog(20'h012, 16'h1234);
    expect_eq("prog_ry_pre", ry, 32'h1);
    measure_low(100, lows);
    expect_eq("prog_busy_clks", lows, 32'd16);
    bus_read(20'h012, rd, ro);
    expect_eq("prog_read", rd, 32'h1234);

    // Held read follows the address with one clock of latency
    @(negedge clk);
    addr = 20'h012; ce_n = 1'b0; oe_n = 1'b0;
    @(negedge clk);
    expect_eq("track_a", rdata, 32'h1234);
    addr = 20'h013;
    @(negedge clk);
    expect_eq("track_b", rdata, 32'hFFFF);
    ce_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    expect_eq("track_oe_fall", doe, 32'h0);

    // AND semantics, plus status polling while busy
    cmd_prog(20'h012, 16'h00FF);
    bus_read(20'h012, rd, ro);
    expect_eq("status_1", rd, 32'h0080);
    bus_read(20'h012, rd, ro);
    expect_eq("status_2", rd, 32'h00C0);
    measure_low(100, lows);
    bus_read(20'h012, rd, ro);
    expect_eq("and_read", rd, 32'h0034);

    // WE# and OE# both low is a write: the target must not drive the bus
    @(negedge clk);
    addr = 20'h100; wdata = 16'h0000; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_eq("both_low_oe", doe, 32'h0);
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);

    // Broken unlock sequence must not program
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0066);
    bus_write(20'h555, 16'h00A0);
    bus_write(20'h020, 16'h5555);
    measure_low(20, lows);
    expect_eq("broken_busy_clks", lows, 32'd0);
    bus_read(20'h020, rd, ro);
    expect_eq("broken_read", rd, 32'hFFFF);

`ifdef NOR_EMU_ERASE_EN
    prog_wait(20'h040, 16'hABCD);
    prog_wait(20'h03F, 16'h1111);
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h555, 16'h0080);
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h012, 16'h0030);
    measure_low(200, lows);
    expect_eq("erase_busy_clks", lows, 32'd64);
    bus_read(20'h012, rd, ro);
    expect_eq("erase_012", rd, 32'hFFFF);
    bus_read(20'h03F, rd, ro);
    expect_eq("erase_03f", rd, 32'hFFFF);
    bus_read(20'h040, rd, ro);
    expect_eq("erase_keep_040", rd, 32'hABCD);

    // Reset part-way through an erase keeps the unerased tail
    prog_wait(20'h000, 16'h4444);
    prog_wait(20'h010, 16'h2222);
    prog_wait(20'h03F, 16'h3333);
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h555, 16'h0080);
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h000, 16'h0030);
    for (int i = 0; i < 20; i++) begin
      if (!ry) break;
      @(negedge clk);
    end
    expect_eq("erase2_started", ry, 32'h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_eq("erase_abort_ry", ry, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(20'h000, rd, ro);
    expect_eq("abort_erased_000", rd, 32'hFFFF);
    bus_read(20'h010, rd, ro);
    expect_eq("abort_keep_010", rd, 32'h2222);
    bus_read(20'h03F, rd, ro);
    expect_eq("abort_keep_03f", rd, 32'h3333);
`else
    // Without erase support the 80h sequence is rejected
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h555, 16'h0080);
    bus_write(20'h555, 16'h00AA);
    bus_write(20'h2AA, 16'h0055);
    bus_write(20'h012, 16'h0030);
    measure_low(100, lows);
    expect_eq("no_erase_busy_clks", lows, 32'd0);
    bus_read(20'h012, rd, ro);
    expect_eq("no_erase_read", rd, 32'h0034);
`endif

    // Reset during a program aborts it with the word unchanged
    cmd_prog(20'h050, 16'h0000);
    repeat (5) @(negedge clk);
    expect_eq("prog2_busy", ry, 32'h0);
    rst_n = 1'b0;
    #1;
    expect_eq("prog_abort_ry", ry, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    bus_read(20'h050, rd, ro);
    expect_eq("prog_abort_read", rd, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor_target_emu.md
# nor_target_emu

Synthesizable parallel-NOR target emulator: the device side of the NOR pin bus driven by the bridge's NOR bus master. It sits on the same `sys_clk_i` domain as the master and decodes CE#/WE#/OE# strobes into reads and JEDEC-style unlock/program/sector-erase commands on an on-chip word array. It also drives RY/BY# busy timing and data-polling status, so the bridge can be exercised in loopback on hardware and in simulation without a flash part.

## Interface
- `MEMWBADDRBITS`, default `` `NORADDRBITS ``: width of the NOR address bus.
- `MEMWBDATABITS`, default `` `NORDATABITS `` (16): width of the NOR data bus.
- `MEMBITS`, default 10: emulated array depth of 2^MEMBITS words. Upper address bits are ignored (aliasing).
- `SECTBITS`, default 6: sector size of 2^SECTBITS words. Must be ≤ MEMBITS.
- `PROG_CYCLES`, default 16: program busy time in clocks. Must be ≥ 1.
- `sys_clk_i` in 1: the single clock for the block.
- `sys_rst_i` in 1: reset, asynchronous and active-low.
- `nor_ce_i` in 1: chip enable, active-low.
- `nor_we_i` in 1: write enable, active-low.
- `nor_oe_i` in 1: output enable, active-low.
- `nor_addr_i` in MEMWBADDRBITS: word address.
- `nor_data_i` in MEMWBDATABITS: write data from the master.
- `nor_data_o` out MEMWBDATABITS: read data or status word.
- `nor_data_oe` out 1: 1 = target drives the data bus.
- `nor_ry_o` out 1: 1 = ready, 0 = busy.

## Operation
- **Strobe decode**, sampled each clock:
  - write phase = !ce && !we.
  - read phase = !ce && !oe && we.
  - If WE# and OE# are both low, the cycle is a write and `nor_data_oe` = 0.
- **Write capture and commit.**
  - Address and data are latched on every write-phase cycle.
  - The bus write commits on the first cycle where the write phase ends, i.e. the WE# or CE# rising edge, detected with a registered previous-phase flag.
  - The committed write uses the latched values, not the current pins.
- **Command FSM** (unlock compare on `addr[10:0]`, data compare on `data[7:0]`):
  - IDLE: AA@555 → UNLK1.
  - UNLK1: 55@2AA → UNLK2.
  - UNLK2: A0@555 → PROG; 80@555 → ERS1.
  - ERS1: AA@555 → ERS2.
  - ERS2: 55@2AA → ERS3.
  - ERS3: 30@any → BUSY_ERASE on sector `addr[MEMBITS-1:SECTBITS]`.
  - PROG: any write → BUSY_PROG. It latches address and `pdata = mem[addr] & data`, so bits only go 1→0.
  - Any other write, including F0, returns the FSM to IDLE.
  - All writes are ignored in BUSY states.
- **BUSY_PROG**
  - Counter runs 0..PROG_CYCLES-1.
  - On the final count, `mem[addr] <= pdata`, then the FSM returns to IDLE.
- **BUSY_ERASE**
  - Word counter walks 0..2^SECTBITS-1, writing all-ones to one word per cycle, then the FSM returns to IDLE.
- **Reads, idle**
  - `nor_data_o <= mem[addr[MEMBITS-1:0]]`.
- **Reads, busy (status word)**
  - bit7 = ~pdata[7] (program) or 0 (erase).
  - bit6 = toggle bit. It inverts on each read-phase entry (OE# or CE# falling) while busy.
  - All other bits are 0.
- **Reset** (`sys_rst_i` low):
  - FSM goes to IDLE, counters to 0, toggle bit to 0.
  - An in-flight program is aborted with the array word unchanged.
  - An in-flight erase leaves its prefix erased.
  - Array contents are not reset. The array initialises to all-ones at configuration.

## Timing
- Output reset values: `nor_data_o` = 0, `nor_data_oe` = 0, `nor_ry_o` = 1.
- Read latency: `nor_data_o` and `nor_data_oe` are registered.
  - Valid 1 clock after the read phase is sampled, then tracking the address with 1-clock latency.
  - `nor_data_oe` falls 1 clock after the read phase ends.
- Write commit happens 1 clock after the strobe rising edge. The FSM state update takes effect that clock.
- Program busy timing:
  - `nor_ry_o` falls 1 clock after the program commit.
  - It stays low exactly PROG_CYCLES clocks.
  - The array is updated in the same clock `nor_ry_o` rises.
- Erase busy timing:
  - `nor_ry_o` is low for 2^SECTBITS clocks.
  - It starts 1 clock after the 30h commit.
- Counters are COUNTERBITS-wide unsigned values with no wrap beyond terminal count. Address aliasing is modulo 2^MEMBITS.

## Configuration
- `NOR_EMU_ERASE_EN` defined:
  - The 80h/AA/55/30 sector-erase path and the BUSY_ERASE state are compiled in.
- `NOR_EMU_ERASE_EN` undefined:
  - 80@555 in UNLK2 is treated as an invalid write and returns the FSM to IDLE.
  - No erase logic is present.
  - The array can only be programmed 1→0 from its all-ones initial state.

## Test plan
- **Reset values:** assert `sys_rst_i` low mid-clock → `nor_data_o` = 0, `nor_data_oe` = 0, `nor_ry_o` = 1 immediately, without waiting for a clock edge.
- **Fresh read:** read addr 0x012 after configuration → FFFF one clock after OE# low; `nor_data_oe` = 1.
- **Program:** AA@555, 55@2AA, A0@555, 1234@0x012 → `nor_ry_o` low 16 clocks. A read during busy returns bit7 = 1, and bit6 alternates 0/1 across two reads. A read after busy returns 1234.
- **AND semantics:** program 00FF@0x012 over 1234 → reads 0034.
- **Broken sequence:** AA@555, 66@2AA, A0@555, 5555@0x020 → `nor_ry_o` stays 1 and 0x020 still reads FFFF.
- **Sector erase** (`NOR_EMU_ERASE_EN`): erase sector containing 0x012 → `nor_ry_o` low 64 clocks. 0x000–0x03F read FFFF; a word programmed at 0x040 before the erase is unchanged. Asserting reset at clock 10 of the erase leaves 0x010–0x03F unerased and returns `nor_ry_o` = 1.
